wheel_speed_meter: RTL and testbench

Gated pulse-count meter for the car's wheel/encoder input. It synchronises and glitch-filters an asynchronous pulse line, then counts rising edges over a fixed gate window of GATE_CYCLES clk_M cycles (1 s at 50 MHz by default). At the end of each window it publishes the count with a one-cycle valid strobe. It is the measuring counterpart of the system's divider/timebase blocks: it consumes a periodic waveform and reports its rate to the speed display and control logic.

---
 rtl/car_pkg.sv | 17 +
 rtl/wheel_speed_meter_if.sv | 25 ++
 rtl/wheel_speed_meter_sig_filter.sv | 45 ++++
 rtl/wheel_speed_meter.sv | 95 +++++++++
 tb/tb_wheel_speed_meter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/car_pkg.sv
// rtl/car_pkg.sv - shared constants and FSM encodings for the car timing blocks
package car_pkg;

    // Wheel speed meter FSM states
    typedef enum logic {
        S_IDLE = 1'b0,
        S_GATE = 1'b1
    } state_t;

    // System clock rate; the default gate window is one second of it
    localparam int CLK_HZ          = 50_000_000;
    localparam int GATE_CYCLES_DEF = CLK_HZ;
    localparam int FILT_CYCLES_DEF = 4;
    localparam int CNT_W_DEF       = 16;
    localparam int GATE_W_DEF      = 32;

endpackage

// File: rtl/wheel_speed_meter_if.sv
// rtl/wheel_speed_meter_if.sv - control/result bundle of the wheel speed meter
interface wheel_speed_meter_if
    import car_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             overflow;
    logic             busy;

    // Consumer side: drives enable and the raw pulse line, reads results
    modport master (
        output en, sig_in,
        input  count_out, count_valid, overflow, busy
    );

    // Meter side
    modport slave (
        input  en, sig_in,
        output count_out, count_valid, overflow, busy
    );
endinterface

// File: rtl/wheel_speed_meter_sig_filter.sv
// rtl/wheel_speed_meter_sig_filter.sv - synchroniser, glitch filter and rising-edge detector
module sig_filter #(
    parameter int FILT_CYCLES = 4
) (
    input  logic clk_M,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);
    localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic [FW-1:0] r_stable_cnt;
    logic          r_level;
    logic          r_rise;

    // Two-flop synchroniser, then accept a level change only after it has held FILT_CYCLES samples
    always_ff @(posedge clk_M or posedge reset) begin
        if (reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_stable_cnt <= '0;
            r_level      <= 1'b0;
            r_rise       <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_stable_cnt <= '0;
            end else if (r_stable_cnt == FW'(FILT_CYCLES - 1)) begin
                r_level      <= r_sync2;
                r_rise       <= r_sync2;
                r_stable_cnt <= '0;
            end else begin
                r_stable_cnt <= r_stable_cnt + FW'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
endmodule

// File: rtl/wheel_speed_meter.sv
// rtl/wheel_speed_meter.sv - gated rising-edge counter reporting pulses per window
module wheel_speed_meter
    import car_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int FILT_CYCLES = FILT_CYCLES_DEF,
    parameter int GATE_W      = GATE_W_DEF
) (
    input  logic                clk_M,
    input  logic                reset,
    wheel_speed_meter_if.slave  bus
);
    state_t            r_state;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_pulse_cnt;
    logic              r_sat;
    logic [CNT_W-1:0]  r_count_out;
    logic              r_count_valid;
    logic              r_overflow;

    logic              w_level;
    logic              w_rise;
    logic              w_edge;
    logic              w_at_max;
    logic [CNT_W-1:0]  w_pulse_next;
    logic              w_sat_next;
    logic              w_close;

    sig_filter #(
        .FILT_CYCLES (FILT_CYCLES)
    ) u_sig_filter (
        .clk_M (clk_M),
        .reset (reset),
        .din   (bus.sig_in),
        .level (w_level),
        .rise  (w_rise)
    );

    // A rise is only ever reported together with the new high level
    assign w_edge       = w_rise & w_level;
    assign w_at_max     = &r_pulse_cnt;
    assign w_pulse_next = (w_edge && !w_at_max) ? r_pulse_cnt + CNT_W'(1) : r_pulse_cnt;
    assign w_sat_next   = r_sat | (w_edge & w_at_max);
    assign w_close      = (r_gate_cnt == GATE_W'(GATE_CYCLES - 1));

    // Gate FSM: open a window on en, publish at its last cycle, abort on en low
    always_ff @(posedge clk_M or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_gate_cnt    <= '0;
            r_pulse_cnt   <= '0;
            r_sat         <= 1'b0;
            r_count_out   <= '0;
            r_count_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_count_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_gate_cnt  <= '0;
                    r_pulse_cnt <= '0;
                    r_sat       <= 1'b0;
                    if (bus.en) begin
                        r_state <= S_GATE;
                    end
                end
                S_GATE: begin
                    if (!bus.en) begin
                        r_state     <= S_IDLE;
                        r_gate_cnt  <= '0;
                        r_pulse_cnt <= '0;
                        r_sat       <= 1'b0;
                    end else if (w_close) begin
                        r_count_out   <= w_pulse_next;
                        r_overflow    <= w_sat_next;
                        r_count_valid <= 1'b1;
                        r_gate_cnt    <= '0;
                        r_pulse_cnt   <= '0;
                        r_sat         <= 1'b0;
                    end else begin
                        r_gate_cnt  <= r_gate_cnt + GATE_W'(1);
                        r_pulse_cnt <= w_pulse_next;
                        r_sat       <= w_sat_next;
                    end
                end
            endcase
        end
    end

    assign bus.count_out   = r_count_out;
    assign bus.count_valid = r_count_valid;
    assign bus.overflow    = r_overflow;
    assign bus.busy        = (r_state == S_GATE);
endmodule

// File: tb/tb_wheel_speed_meter.sv
// tb/tb_wheel_speed_meter.sv - self-checking bench for wheel_speed_meter
module tb_wheel_speed_meter;
    localparam int GATE  = 100;
    localparam int FILT  = 2;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;
    // sig_in driven after edge c is first seen by the gate logic at edge c + LAT
    localparam int LAT   = 1 + 2 + FILT;

    logic clk_M = 1'b0;
    logic reset = 1'b1;
    always #5 clk_M = ~clk_M;

    wheel_speed_meter_if #(.CNT_W(CNT_W)) bus ();

    wheel_speed_meter #(
        .GATE_CYCLES (GATE),
        .CNT_W       (CNT_W),
        .FILT_CYCLES (FILT),
        .GATE_W      (32)
    ) dut (
        .clk_M (clk_M),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int edges[$];
    bit plan[$];
    int run_start = -1;
    bit prev_act  = 1'b0;
    int last_cnt  = 0;
    bit last_ovf  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive next planned input, then check against the window model
    task automatic step();
        bit act;
        bit exp_v;
        int n;
        int keep[$];
        act = bus.en && !reset;
        bus.sig_in = (plan.size() > 0) ? plan.pop_front() : 1'b0;
        @(posedge clk_M);
        cyc++;
        #1;
        if (act && !prev_act) run_start = cyc;
        prev_act = act;
        exp_v = act && (cyc > run_start) && (((cyc - run_start) % GATE) == 0);
        check("busy", bus.busy, act);
        check("valid", bus.count_valid, exp_v);
        if (exp_v) begin
            n = 0;
            foreach (edges[k]) begin
                if (edges[k] > cyc - GATE && edges[k] <= cyc) n++;
                if (edges[k] > cyc) keep.push_back(edges[k]);
            end
            edges    = keep;
            last_cnt = (n > MAXC) ? MAXC : n;
            last_ovf = (n > MAXC);
        end
        check("count_out", bus.count_out, last_cnt);
        check("overflow", bus.overflow, last_ovf);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic play();
        while (plan.size() > 0) step();
    endtask

    task automatic add_low(input int n);
        for (int i = 0; i < n; i++) plan.push_back(1'b0);
    endtask

    // Clean pulse: one counted edge; optional one-cycle dropout that must not add a second edge
    task automatic add_pulse(input int h, input bit dropout);
        edges.push_back(cyc + plan.size() + LAT);
        for (int i = 0; i < h; i++) plan.push_back(1'b1);
        if (dropout) begin
            plan.push_back(1'b0);
            for (int i = 0; i < h; i++) plan.push_back(1'b1);
        end
    endtask

    task automatic add_glitch();
        plan.push_back(1'b1);
        add_low(2);
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * GATE && !seen; i++) begin
            step();
            seen = bus.count_valid;
        end
        check("wait_valid_timeout", seen, 1'b1);
    endtask

    initial begin
        bus.en     = 1'b0;
        bus.sig_in = 1'b0;
        reset      = 1'b1;
        run(3);
        reset = 1'b0;
        run(2);

        // Reset part-way through a window that has seen 3 edges
        bus.en = 1'b1;
        add_low(2);
        for (int i = 0; i < 3; i++) begin add_pulse(3, 1'b0); add_low(3); end
        add_low(10);
        play();
        reset = 1'b1;
        #1;
        check("rst_count_out", bus.count_out, 0);
        check("rst_valid", bus.count_valid, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_busy", bus.busy, 0);
        edges.delete();
        last_cnt  = 0;
        last_ovf  = 1'b0;
        prev_act  = 1'b0;
        run_start = -1;
        run(3);
        reset = 1'b0;
        run(GATE + 5);
        bus.en = 1'b0;
        run(3);

        // Seven clean pulses from a fresh start, then an empty window
        bus.en = 1'b1;
        for (int i = 0; i < 7; i++) begin add_pulse(6, 1'b0); add_low(6); end
        play();
        run(2 * GATE);

        // Glitches mixed with five clean pulses of random shape
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            add_low($urandom_range(2, 4));
            add_glitch();
            add_pulse($urandom_range(2, 5), 1'($urandom_range(0, 1)));
            add_low(2);
        end
        play();
        run(GATE);

        // Twenty fastest-rate pulses saturate; next window carries three
        wait_valid();
        for (int i = 0; i < 20; i++) begin add_pulse(2, 1'b0); add_low(2); end
        add_low(20);
        for (int i = 0; i < 3; i++) begin add_pulse(3, 1'b0); add_low(3); end
        play();
        run(GATE);

        // Edge in the closing cycle, then an edge in the first cycle of a window
        wait_valid();
        add_low(GATE - LAT);
        add_pulse(3, 1'b0);
        add_low(GATE - 2);
        add_pulse(3, 1'b0);
        add_low(10);
        play();
        run(GATE);

        // Abort at gate_cnt 50, then a fresh window after re-enable
        wait_valid();
        add_low(5);
        add_pulse(4, 1'b0);
        add_low(4);
        add_pulse(4, 1'b0);
        run(50);
        bus.en = 1'b0;
        run(GATE + 10);
        bus.en = 1'b1;
        add_pulse(4, 1'b0);
        add_low(4);
        play();
        run(GATE + 5);

        // Random traffic across several windows with a random abort
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 12; i++) begin
                add_low($urandom_range(2, 6));
                if ($urandom_range(0, 3) == 0) begin add_glitch(); end
                add_pulse($urandom_range(2, 6), 1'($urandom_range(0, 1)));
            end
            add_low(2);
            play();
        end
        run($urandom_range(10, 90));
        bus.en = 1'b0;
        run(5);
        bus.en = 1'b1;
        run(GATE + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
